// File: rtl/mc_controller.sv
// ----------------------------------------------------------------------------
// mc_controller
//   Multi-cycle control unit for the RV32 datapath. A Moore FSM walks each
//   instruction through Fetch/Decode/Execute/Writeback. The op/funct3/funct7
//   fields are latched when FETCH is left, and every later state decodes only
//   that latched copy. Unsupported encodings park the FSM in TRAP and raise
//   the sticky 'illegal' flag until reset. 'instret' counts retired
//   instructions.
//
//   Build option: define MC_BNE_EN to accept funct3=001 (bne) in the branch
//   state. Without it a bne encoding is treated as illegal.
//
// Ports
//   clk, reset          clock; asynchronous active-low reset
//   op/funct3/funct7    instruction fields from the datapath (valid in FETCH)
//   Zero                ALU zero flag (branch decision)
//   PCWrite..RegWrite   datapath control outputs
//   illegal             sticky unsupported-instruction flag
//   state               current FSM state (debug)
//   instret             retired-instruction count, wraps at 2^CNT_W
// ----------------------------------------------------------------------------
module mc_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             Zero,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [1:0]       ResultSrc,
    output logic [2:0]       ALUControl,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUSrcA,
    output logic [2:0]       ImmSrc,
    output logic             RegWrite,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instret
);

    localparam logic [3:0] S_FETCH   = 4'd0,  S_DECODE  = 4'd1,
                           S_MEMADR  = 4'd2,  S_MEMREAD = 4'd3,
                           S_MEMWB   = 4'd4,  S_MEMWR   = 4'd5,
                           S_EXEC_R  = 4'd6,  S_ALUWB   = 4'd7,
                           S_EXEC_I  = 4'd8,  S_JAL     = 4'd9,
                           S_BEQ     = 4'd10, S_EXEC_U  = 4'd11,
                           S_TRAP    = 4'd15;

    localparam logic [6:0] OP_LW  = 7'b0000011, OP_SW  = 7'b0100011,
                           OP_R   = 7'b0110011, OP_I   = 7'b0010011,
                           OP_LUI = 7'b0110111, OP_JAL = 7'b1101111,
                           OP_BR  = 7'b1100011;

    logic [3:0] state_n;
    logic [6:0] op_q;
    logic [2:0] f3_q;
    logic [6:0] f7_q;
    logic [2:0] alu_dec;
    logic       alu_ok;
    logic       br_ok, br_take;
    logic       pc_we, mem_we, ir_we, reg_we;

    // Only funct7[5] matters for decoding; the rest is latched for completeness.
    logic unused_f7;
    assign unused_f7 = ^{f7_q[6], f7_q[4:0]};

    // ALU decoder: R and I types share it; only R-type honours funct7[5] (sub).
    always_comb begin
        alu_dec = 3'b000;
        alu_ok  = 1'b1;
        case (f3_q)
            3'b000:  alu_dec = (op_q == OP_R && f7_q[5]) ? 3'b001 : 3'b000;
            3'b010:  alu_dec = 3'b101;
            3'b110:  alu_dec = 3'b011;
            3'b111:  alu_dec = 3'b010;
            default: alu_ok  = 1'b0;
        endcase
    end

`ifdef MC_BNE_EN
    assign br_ok   = (f3_q == 3'b000) || (f3_q == 3'b001);
    assign br_take = (f3_q == 3'b001) ? ~Zero : Zero;
`else
    assign br_ok   = (f3_q == 3'b000);
    assign br_take = Zero;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_FETCH;
        else        state <= state_n;
    end

    // Field latch: datapath fields are only trustworthy during FETCH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q <= '0;
            f3_q <= '0;
            f7_q <= '0;
        end else if (state == S_FETCH) begin
            op_q <= op;
            f3_q <= funct3;
            f7_q <= funct7;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 illegal <= 1'b0;
        else if (state_n == S_TRAP) illegal <= 1'b1;
    end

    // Retire on the final state of every legal instruction path.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            instret <= '0;
        else if (state == S_MEMWB || state == S_MEMWR ||
                 state == S_ALUWB || state == S_BEQ)
            instret <= instret + 1'b1;
    end

    // Next-state logic
    always_comb begin
        state_n = S_TRAP;
        case (state)
            S_FETCH:   state_n = S_DECODE;
            S_DECODE: begin
                case (op_q)
                    OP_LW, OP_SW: state_n = S_MEMADR;
                    OP_R:         state_n = S_EXEC_R;
                    OP_I:         state_n = S_EXEC_I;
                    OP_LUI:       state_n = S_EXEC_U;
                    OP_JAL:       state_n = S_JAL;
                    OP_BR:        state_n = br_ok ? S_BEQ : S_TRAP;
                    default:      state_n = S_TRAP;
                endcase
            end
            S_MEMADR:  state_n = (op_q == OP_LW) ? S_MEMREAD : S_MEMWR;
            S_MEMREAD: state_n = S_MEMWB;
            S_MEMWB:   state_n = S_FETCH;
            S_MEMWR:   state_n = S_FETCH;
            S_EXEC_R:  state_n = alu_ok ? S_ALUWB : S_TRAP;
            S_EXEC_I:  state_n = alu_ok ? S_ALUWB : S_TRAP;
            S_EXEC_U:  state_n = S_ALUWB;
            S_ALUWB:   state_n = S_FETCH;
            S_JAL:     state_n = S_ALUWB;
            S_BEQ:     state_n = S_FETCH;
            default:   state_n = S_TRAP;
        endcase
    end

    // Output logic (Moore, plus Zero for the branch PC enable)
    always_comb begin
        pc_we      = 1'b0;
        mem_we     = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUControl = 3'b000;
        ALUSrcB    = 2'b00;
        ALUSrcA    = 2'b00;
        ImmSrc     = 3'b000;
        case (state)
            S_FETCH: begin
                ir_we = 1'b1; pc_we = 1'b1;
                ALUSrcB = 2'b10; ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01; ALUSrcB = 2'b01;
                ImmSrc  = (op_q == OP_JAL) ? 3'b011 : 3'b010;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10; ALUSrcB = 2'b01;
                ImmSrc  = (op_q == OP_SW) ? 3'b001 : 3'b000;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB:   begin ResultSrc = 2'b01; reg_we = 1'b1; end
            S_MEMWR:   begin AdrSrc = 1'b1; mem_we = 1'b1; end
            S_EXEC_R:  begin ALUSrcA = 2'b10; ALUControl = alu_dec; end
            S_EXEC_I: begin
                ALUSrcA = 2'b10; ALUSrcB = 2'b01; ALUControl = alu_dec;
            end
            S_EXEC_U:  begin ALUSrcA = 2'b11; ALUSrcB = 2'b01; ImmSrc = 3'b100; end
            S_ALUWB:   reg_we = 1'b1;
            S_JAL:     begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; pc_we = 1'b1; end
            S_BEQ: begin
                ALUSrcA = 2'b10; ALUControl = 3'b001; pc_we = br_take;
            end
            default: ;
        endcase
    end

    // FETCH is the reset state but must not write anything while reset is held.
    assign PCWrite  = pc_we  & reset;
    assign IRWrite  = ir_we  & reset;
    assign MemWrite = mem_we & reset;
    assign RegWrite = reg_we & reset;

endmodule

// File: tb/tb_mc_controller.sv
// ----------------------------------------------------------------------------
// tb_mc_controller
//   Randomized instruction stream against an instruction-level reference
//   model. The stimulus process expands each instruction into its expected
//   per-cycle control record and queues it; a monitor pops one record per
//   cycle and compares it against the DUT outputs.
// ----------------------------------------------------------------------------
module tb_mc_controller;

    typedef struct packed {
        logic [3:0]  st;
        logic        pcw, adr, memw, irw;
        logic [1:0]  res;
        logic [2:0]  alu;
        logic [1:0]  srcb, srca;
        logic [2:0]  imm;
        logic        regw, ill;
        logic [31:0] cnt;
    } rec_t;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           IT = 7'b0010011, LUI = 7'b0110111, JAL = 7'b1101111,
                           BR = 7'b1100011;
`ifdef MC_BNE_EN
    localparam bit BNE_EN = 1'b1;
`else
    localparam bit BNE_EN = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b0, Zero = 1'b0;
    logic [6:0]  op = '0, funct7 = '0;
    logic [2:0]  funct3 = '0;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0]  ResultSrc, ALUSrcB, ALUSrcA;
    logic [2:0]  ALUControl, ImmSrc;
    logic [3:0]  state;
    logic [31:0] instret;

    rec_t        q[$];
    int          checks = 0, failures = 0;
    logic [31:0] instret_m = '0;

    mc_controller #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7(funct7),
        .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
        .ALUSrcB(ALUSrcB), .ALUSrcA(ALUSrcA), .ImmSrc(ImmSrc),
        .RegWrite(RegWrite), .illegal(illegal), .state(state), .instret(instret)
    );

    always #5 clk = ~clk;

    // ---- reference model ---------------------------------------------------
    function automatic bit alu_legal(logic [2:0] f3);
        return f3 == 3'b000 || f3 == 3'b010 || f3 == 3'b110 || f3 == 3'b111;
    endfunction

    // ALU operation implied by the instruction's meaning (add/sub/slt/or/and).
    function automatic logic [2:0] alu_for(logic [6:0] o, logic [2:0] f3, logic [6:0] f7);
        case (f3)
            3'b000:  return (o == RT && f7[5]) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic rec_t reset_rec();
        rec_t r = '0;
        r.res = 2'b10; r.srcb = 2'b10;
        return r;
    endfunction

    function automatic rec_t exp_rec(int st, logic [6:0] o, logic [2:0] f3,
                                     logic [6:0] f7, logic z, logic [31:0] cnt);
        rec_t r = '0;
        r.st = 4'(st); r.cnt = cnt;
        case (st)
            0:  begin r.pcw = 1; r.irw = 1; r.srcb = 2; r.res = 2; end
            1:  begin r.srca = 1; r.srcb = 1; r.imm = (o == JAL) ? 3 : 2; end
            2:  begin r.srca = 2; r.srcb = 1; r.imm = (o == SW) ? 1 : 0; end
            3:  r.adr = 1;
            4:  begin r.res = 1; r.regw = 1; end
            5:  begin r.adr = 1; r.memw = 1; end
            6:  begin r.srca = 2; r.alu = alu_for(o, f3, f7); end
            7:  r.regw = 1;
            8:  begin r.srca = 2; r.srcb = 1; r.alu = alu_for(o, f3, f7); end
            9:  begin r.srca = 1; r.srcb = 2; r.pcw = 1; end
            10: begin r.srca = 2; r.alu = 3'b001; r.pcw = (f3 == 3'b001) ? ~z : z; end
            11: begin r.srca = 3; r.srcb = 1; r.imm = 4; end
            15: r.ill = 1;
            default: ;
        endcase
        return r;
    endfunction

    // ---- monitor -----------------------------------------------------------
    initial begin
        rec_t e, a;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                a = {state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
                     ALUSrcB, ALUSrcA, ImmSrc, RegWrite, illegal, instret};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL ctl t=%0t state got=%0d exp=%0d rec got=%h exp=%h",
                             $time, a.st, e.st, a, e);
                end
            end
        end
    end

    // ---- stimulus ----------------------------------------------------------
    task automatic do_reset(int n);
        repeat (n) begin
            @(posedge clk); #1;
            reset = 1'b0;
            q.push_back(reset_rec());
        end
        instret_m = '0;
    endtask

    task automatic run_instr(logic [6:0] o, logic [2:0] f3, logic [6:0] f7, int abort_at);
        int seq[5];
        int n;
        case (o)
            LW:  begin seq = '{0, 1, 2, 3, 4}; n = 5; end
            SW:  begin seq = '{0, 1, 2, 5, 0}; n = 4; end
            RT:  begin seq = '{0, 1, 6, alu_legal(f3) ? 7 : 15, 0}; n = 4; end
            IT:  begin seq = '{0, 1, 8, alu_legal(f3) ? 7 : 15, 0}; n = 4; end
            LUI: begin seq = '{0, 1, 11, 7, 0}; n = 4; end
            JAL: begin seq = '{0, 1, 9, 7, 0}; n = 4; end
            BR:  begin
                seq = '{0, 1, (f3 == 0 || (BNE_EN && f3 == 1)) ? 10 : 15, 0, 0}; n = 3;
            end
            default: begin seq = '{0, 1, 15, 0, 0}; n = 3; end
        endcase
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (i == abort_at) begin
                reset = 1'b0;
                q.push_back(reset_rec());
                instret_m = '0;
                do_reset(1);
                return;
            end
            reset = 1'b1;
            if (i == 0) begin
                op = o; funct3 = f3; funct7 = f7;
            end else begin
                // Fields move on once the PC advances; the DUT must ignore them.
                op     = $urandom_range(0, 1) ? 7'd0 : 7'($urandom);
                funct3 = 3'($urandom);
                funct7 = 7'($urandom);
            end
            Zero = 1'($urandom);
            q.push_back(exp_rec(seq[i], o, f3, f7, Zero, instret_m));
        end
        if (seq[n-1] == 15) begin
            repeat (10) begin
                @(posedge clk); #1;
                Zero = 1'($urandom); op = 7'($urandom);
                q.push_back(exp_rec(15, o, f3, f7, Zero, instret_m));
            end
            do_reset(2);
        end else begin
            instret_m = instret_m + 1;
        end
    endtask

    initial begin
        logic [6:0] o, f7;
        logic [2:0] f3;
        int         k, ab;
        logic [2:0] legal_f3[4];
        legal_f3 = '{3'b000, 3'b010, 3'b110, 3'b111};

        do_reset(2);
        // directed
        run_instr(RT, 3'b000, 7'b0000000, -1);
        run_instr(RT, 3'b000, 7'b0100000, -1);
        run_instr(RT, 3'b110, 7'b0000000, -1);
        run_instr(IT, 3'b000, 7'b0100000, -1);
        run_instr(LW, 3'b010, 7'b0000000, -1);
        run_instr(SW, 3'b010, 7'b0000000, -1);
        run_instr(LUI, 3'b000, 7'b0000000, -1);
        run_instr(JAL, 3'b000, 7'b0000000, -1);
        repeat (4) run_instr(BR, 3'b000, 7'b0000000, -1);
        run_instr(BR, 3'b001, 7'b0000000, -1);
        run_instr(RT, 3'b001, 7'b0000000, -1);
        run_instr(7'b0000000, 3'b000, 7'b0000000, -1);
        run_instr(RT, 3'b111, 7'b0000000, -1);
        run_instr(SW, 3'b010, 7'b0000000, 3);   // reset while in MEMWR

        // randomized stream
        repeat (250) begin
            k  = $urandom_range(0, 9);
            f3 = ($urandom_range(0, 7) != 0) ? legal_f3[$urandom_range(0, 3)] : 3'($urandom);
            f7 = $urandom_range(0, 1) ? 7'b0100000 : 7'($urandom);
            case (k)
                0: o = LW;
                1: o = SW;
                2, 3: o = RT;
                4: o = IT;
                5: o = LUI;
                6: o = JAL;
                7, 8: begin
                    o  = BR;
                    f3 = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'($urandom_range(0, 1));
                end
                default: begin
                    o = 7'($urandom);
                    while (o == LW || o == SW || o == RT || o == IT ||
                           o == LUI || o == JAL || o == BR)
                        o = 7'($urandom);
                end
            endcase
            ab = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 2) : -1;
            run_instr(o, f3, f7, ab);
        end

        // drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending got=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
Multi-cycle control unit for the RV32 datapath; sits directly upstream of it and drives every datapath control input. Moore FSM sequences Fetch/Decode/Execute/Writeback per instruction from the op/funct3/funct7 fields and the ALU Zero flag. Includes an ALU decoder, an instruction field latch, an illegal-instruction trap and a retired-instruction counter.

Parameters:
CNT_W, 32, width of retired-instruction counter instret

Ports:
clk  in  1  clock, all state changes on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
op  in  7  opcode from datapath (memory read data, valid in FETCH)
funct3  in  3  funct3 from datapath (valid in FETCH)
funct7  in  7  funct7 from datapath (valid in FETCH)
Zero  in  1  ALU zero flag
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address select: 0 PC, 1 Result
MemWrite  out  1  memory write enable
IRWrite  out  1  instruction/OldPC register enable
ResultSrc  out  2  00 ALUOut, 01 mem data, 10 ALUResult
ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
ALUSrcB  out  2  00 reg B, 01 ImmExt, 10 constant 4
ALUSrcA  out  2  00 PC, 01 OldPC, 10 reg A, 11 zero
ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
RegWrite  out  1  register file write enable
illegal  out  1  sticky: unsupported instruction decoded
state  out  4  current FSM state (debug)
instret  out  CNT_W  count of completed instructions

Behaviour:
- Reset low: state=FETCH, field latch=0, illegal=0, instret=0; PCWrite/IRWrite/MemWrite/RegWrite forced 0 while reset low. Other outputs take FETCH values.
- Field latch: op/funct3/funct7 captured on the clk edge leaving FETCH; all later states decode the latched copy only (datapath inputs change once PC advances).
- Outputs are pure functions of state + latched fields (+ Zero for PCWrite in BEQ); signals not listed below are 0 (ALUControl add).
- FETCH(0): AdrSrc0, IRWrite1, SrcA00, SrcB10, add, ResultSrc10, PCWrite1 -> DECODE.
- DECODE(1): SrcA01, SrcB01, add, ImmSrc J if op=1101111 else B. Next by op: 0000011/0100011 MEMADR; 0110011 EXEC_R; 0010011 EXEC_I; 0110111 EXEC_U; 1101111 JAL; 1100011 BEQ; other -> TRAP.
- MEMADR(2): SrcA10, SrcB01, add, ImmSrc I (lw) / S (sw) -> MEMREAD (lw) or MEMWR (sw).
- MEMREAD(3): ResultSrc00, AdrSrc1 -> MEMWB. MEMWB(4): ResultSrc01, RegWrite1 -> FETCH.
- MEMWR(5): ResultSrc00, AdrSrc1, MemWrite1 -> FETCH.
- EXEC_R(6): SrcA10, SrcB00, ALU decoder -> ALUWB. EXEC_I(8): SrcA10, SrcB01, ImmSrc I, ALU decoder -> ALUWB. EXEC_U(11): SrcA11, SrcB01, ImmSrc U, add -> ALUWB.
- ALUWB(7): ResultSrc00, RegWrite1 -> FETCH.
- JAL(9): SrcA01, SrcB10, add, ResultSrc00, PCWrite1 -> ALUWB (rd gets OldPC+4).
- BEQ(10): SrcA10, SrcB00, sub, ResultSrc00, PCWrite=Zero -> FETCH. funct3 other than 000 -> TRAP instead.
- ALU decoder: funct3 000 -> sub if R-type and funct7[5]=1, else add; 010 slt; 110 or; 111 and; any other funct3 in EXEC_R/EXEC_I -> TRAP next cycle (no RegWrite issued).
- TRAP(15): all enables 0, illegal=1, stays until reset.
- Cycle counts: lw 5, sw/R/I/lui/jal-minus-WB 4 (jal 4), beq 3.
- instret +1 (wraps at 2^CNT_W) on the edge leaving MEMWB, MEMWR, ALUWB, BEQ; not on TRAP entry.
- Reset asserted mid-instruction: immediate return to FETCH, no partial write enables.

Optional Feature:
MC_BNE_EN: defined -> BEQ state also accepts funct3 001 (bne), PCWrite=~Zero; undefined -> funct3 001 branch goes to TRAP.

Test Plan:
- Release reset, op=0110011 f3=000 f7=0000000 (add) -> states 0,1,6,7,0; RegWrite=1 only in state 7; ALUControl=000 in 6; instret=1.
- Same with f7=0100000 -> ALUControl=001 in EXEC_R; f3=110 -> 011.
- lw (op 0000011, f3 010) -> 0,1,2,3,4,0; AdrSrc=1 in 3; ResultSrc=01, RegWrite=1 in 4; sw (0100011) -> MemWrite=1 only in 5, ImmSrc=001 in 2.
- beq Zero=1 -> PCWrite=1 in state 10; Zero=0 -> PCWrite=0; instret +1 both cases; bne with/without MC_BNE_EN -> PCWrite=~Zero / illegal=1.
- op changed to 0000000 during DECODE after latching add -> still follows add path; op=0000000 latched -> TRAP, illegal=1, enables 0 for 10 cycles.
- Drive reset low while in MEMWR -> MemWrite drops to 0 same cycle, state=0, instret=0.
